// File: rtl/fpdiv_pkg.sv
// Shared definitions for the floating-point divide request path: format
// codes, rounding-mode codes and the packed request payload.
package fpdiv_pkg;

  localparam logic [1:0] FMT_F16 = 2'b00;
  localparam logic [1:0] FMT_F32 = 2'b01;
  localparam logic [1:0] FMT_F64 = 2'b10;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [2:0]  rm;
  } fpdiv_req_t;

  localparam int REQ_W = $bits(fpdiv_req_t);

endpackage

// File: rtl/fpdiv_req_fifo.sv
// Generic DEPTH x W circular buffer. Pointers wrap naturally (DEPTH is a
// power of two); full/empty come from the occupancy counter. Push is refused
// when full even if a pop happens in the same cycle.
module fpdiv_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 wdata_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next-state pointers and occupancy; flush returns everything to empty.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; only count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fpdiv_issue_queue.sv
// Request buffer in front of fpdiv_scalar. Holds up to DEPTH tagged divide
// requests in order, issues them one at a time and returns each result with
// its original tag. flush_i drops queued and in-flight work together.
// Optional macro FPDIV_ISSUE_QUEUE_BYPASS_EN: when idle and empty, a new
// request is offered to the divider in the same cycle it arrives.
module fpdiv_issue_queue
  import fpdiv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_fp_format_i,
  input  logic [63:0]                 req_opa_i,
  input  logic [63:0]                 req_opb_i,
  input  logic [2:0]                  req_rm_i,
  input  logic [TAG_W-1:0]            req_tag_i,
  output logic                        div_start_valid_o,
  input  logic                        div_start_ready_i,
  output logic                        div_flush_o,
  output logic [1:0]                  div_fp_format_o,
  output logic [63:0]                 div_opa_o,
  output logic [63:0]                 div_opb_o,
  output logic [2:0]                  div_rm_o,
  input  logic                        div_finish_valid_i,
  output logic                        div_finish_ready_o,
  input  logic [63:0]                 div_res_i,
  input  logic [4:0]                  div_fflags_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [63:0]                 rsp_res_o,
  output logic [4:0]                  rsp_fflags_o,
  output logic [TAG_W-1:0]            rsp_tag_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  fpdiv_req_t       new_req, head_req, issue_req;
  logic [TAG_W-1:0] head_tag, issue_tag;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             bypass_act, start_valid, issue_fire;
  logic             finish_ready, rsp_valid;

  assign new_req = '{fmt: req_fp_format_i, opa: req_opa_i, opb: req_opb_i, rm: req_rm_i};

`ifdef FPDIV_ISSUE_QUEUE_BYPASS_EN
  assign bypass_act = (state_q == ST_IDLE) && fifo_empty && req_valid_i && !flush_i;
`else
  assign bypass_act = 1'b0;
`endif

  assign req_ready_o = !fifo_full && !flush_i;
  assign issue_fire  = start_valid && div_start_ready_i;
  // A bypassed request that is taken immediately never occupies a slot.
  assign fifo_push   = req_valid_i && req_ready_o && !(bypass_act && div_start_ready_i);
  assign fifo_pop    = issue_fire && !bypass_act;

  fpdiv_req_fifo #(
    .DEPTH (DEPTH),
    .W     (REQ_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .wdata_i ({new_req, req_tag_i}),
    .pop_i   (fifo_pop),
    .rdata_o ({head_req, head_tag}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  // Issue/response FSM: one operation in flight, tag held until its result returns.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    start_valid  = 1'b0;
    finish_ready = 1'b0;
    rsp_valid    = 1'b0;
    issue_req    = bypass_act ? new_req : head_req;
    issue_tag    = bypass_act ? req_tag_i : head_tag;
    case (state_q)
      ST_IDLE: begin
        start_valid = !flush_i && (!fifo_empty || bypass_act);
        if (start_valid && div_start_ready_i) begin
          state_d = ST_BUSY;
          tag_d   = issue_tag;
        end
      end
      ST_BUSY: begin
        finish_ready = rsp_ready_i && !flush_i;
        rsp_valid    = div_finish_valid_i && !flush_i;
        if (div_finish_valid_i && rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) state_d = ST_IDLE;
  end

  // FSM state and in-flight tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  // Divider-facing outputs; data is zeroed when not offered so reset leaves every output low.
  always_comb begin
    div_start_valid_o  = start_valid;
    div_flush_o        = flush_i;
    div_fp_format_o    = start_valid ? issue_req.fmt : 2'b00;
    div_opa_o          = start_valid ? issue_req.opa : 64'd0;
    div_opb_o          = start_valid ? issue_req.opb : 64'd0;
    div_rm_o           = start_valid ? issue_req.rm  : 3'd0;
    div_finish_ready_o = finish_ready;
  end

  // Response pass-through from the divider, tagged with the in-flight tag.
  always_comb begin
    rsp_valid_o  = rsp_valid;
    rsp_res_o    = rsp_valid ? div_res_i : 64'd0;
    rsp_fflags_o = rsp_valid ? div_fflags_i : 5'd0;
    rsp_tag_o    = tag_q;
  end

endmodule

// File: tb/tb_fpdiv_issue_queue.sv
// Self-checking bench for fpdiv_issue_queue. A queue-based reference model
// predicts readiness, issue, occupancy and responses each cycle; a stub
// divider with a programmable latency answers the issued operations.
module tb_fpdiv_issue_queue;
  import fpdiv_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [1:0]       fmt;
    logic [63:0]      opa;
    logic [63:0]      opb;
    logic [2:0]       rm;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic req_valid_i = 1'b0;
  logic req_ready_o;
  logic [1:0] req_fp_format_i = '0;
  logic [63:0] req_opa_i = '0, req_opb_i = '0;
  logic [2:0] req_rm_i = '0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic div_start_valid_o, div_start_ready_i = 1'b0, div_flush_o;
  logic [1:0] div_fp_format_o;
  logic [63:0] div_opa_o, div_opb_o;
  logic [2:0] div_rm_o;
  logic div_finish_valid_i = 1'b0, div_finish_ready_o;
  logic [63:0] div_res_i = '0;
  logic [4:0] div_fflags_i = '0;
  logic rsp_valid_o, rsp_ready_i = 1'b0;
  logic [63:0] rsp_res_o;
  logic [4:0] rsp_fflags_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  fpdiv_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_fp_format_i(req_fp_format_i), .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
    .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
    .div_start_valid_o(div_start_valid_o), .div_start_ready_i(div_start_ready_i),
    .div_flush_o(div_flush_o), .div_fp_format_o(div_fp_format_o),
    .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_rm_o(div_rm_o),
    .div_finish_valid_i(div_finish_valid_i), .div_finish_ready_o(div_finish_ready_o),
    .div_res_i(div_res_i), .div_fflags_i(div_fflags_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_res_o(rsp_res_o), .rsp_fflags_o(rsp_fflags_o), .rsp_tag_o(rsp_tag_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model and stub divider state.
  item_t pending[$];
  item_t inflight_item;
  item_t cur_req;
  logic  inflight = 1'b0;
  logic  stub_busy = 1'b0;
  int    stub_cnt = 0;
  int    dmin = 0, dmax = 0;
  logic  accepted = 1'b0;

  function automatic logic [63:0] res_of(input item_t it);
    return it.opa ^ it.opb ^ 64'h3FF0_0000_0000_0000;
  endfunction

  function automatic logic [4:0] ff_of(input item_t it);
    return it.opb[4:0] ^ {2'b00, it.rm};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input logic [TAG_W-1:0] tag);
    logic [1:0] fmts [3];
    fmts[0] = FMT_F16; fmts[1] = FMT_F32; fmts[2] = FMT_F64;
    cur_req.fmt = fmts[$urandom_range(0, 2)];
    cur_req.opa = {$urandom, $urandom};
    cur_req.opb = {$urandom, $urandom};
    cur_req.rm  = 3'($urandom_range(int'(RM_RNE), int'(RM_RMM)));
    cur_req.tag = tag;
  endtask

  // One clock: drive stub outputs, compare against the model, advance the model.
  task automatic cycle();
    logic byp, exp_ready, exp_sv, exp_rv, iss, fin, push;
    item_t head;
    req_fp_format_i = cur_req.fmt;
    req_opa_i = cur_req.opa;
    req_opb_i = cur_req.opb;
    req_rm_i  = cur_req.rm;
    req_tag_i = cur_req.tag;
    div_finish_valid_i = stub_busy && (stub_cnt == 0);
    div_res_i    = stub_busy ? res_of(inflight_item) : 64'd0;
    div_fflags_i = stub_busy ? ff_of(inflight_item) : 5'd0;
    #1;
    byp = 1'b0;
`ifdef FPDIV_ISSUE_QUEUE_BYPASS_EN
    byp = !inflight && (pending.size() == 0) && req_valid_i && !flush_i;
`endif
    exp_ready = (pending.size() < DEPTH) && !flush_i;
    exp_sv    = !flush_i && !inflight && ((pending.size() > 0) || byp);
    exp_rv    = !flush_i && inflight && div_finish_valid_i;
    head      = byp ? cur_req : ((pending.size() > 0) ? pending[0] : '0);
    check("req_ready", 64'(req_ready_o), 64'(exp_ready));
    check("start_valid", 64'(div_start_valid_o), 64'(exp_sv));
    check("count", 64'(count_o), 64'(pending.size()));
    check("div_flush", 64'(div_flush_o), 64'(flush_i));
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
    if (!flush_i) check("finish_ready", 64'(div_finish_ready_o), 64'(inflight && rsp_ready_i));
    if (exp_sv) begin
      check("div_fmt", 64'(div_fp_format_o), 64'(head.fmt));
      check("div_opa", div_opa_o, head.opa);
      check("div_opb", div_opb_o, head.opb);
      check("div_rm", 64'(div_rm_o), 64'(head.rm));
    end
    if (exp_rv) begin
      check("rsp_res", rsp_res_o, res_of(inflight_item));
      check("rsp_fflags", 64'(rsp_fflags_o), 64'(ff_of(inflight_item)));
      check("rsp_tag", 64'(rsp_tag_o), 64'(inflight_item.tag));
    end
    iss  = exp_sv && div_start_ready_i;
    fin  = exp_rv && rsp_ready_i;
    push = req_valid_i && exp_ready && !(byp && div_start_ready_i);
    accepted = 1'b0;
    if (flush_i) begin
      pending.delete();
      inflight  = 1'b0;
      stub_busy = 1'b0;
    end else begin
      if (stub_busy && stub_cnt > 0) stub_cnt--;
      if (fin) begin
        inflight  = 1'b0;
        stub_busy = 1'b0;
      end
      if (iss) begin
        inflight_item = byp ? cur_req : pending.pop_front();
        inflight  = 1'b1;
        stub_busy = 1'b1;
        stub_cnt  = $urandom_range(dmin, dmax);
      end
      if (push) pending.push_back(cur_req);
      accepted = push || (byp && iss);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic sr, input logic rr, input logic fl);
    req_valid_i = v;
    div_start_ready_i = sr;
    rsp_ready_i = rr;
    flush_i = fl;
    cycle();
    if (accepted) new_req(4'($urandom));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pending.size() > 0 || inflight) && n < 300) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    check("drain_done", 64'(pending.size() == 0 && !inflight), 64'd1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid_i = 1'b0; flush_i = 1'b0; div_start_ready_i = 1'b0;
    div_finish_valid_i = 1'b0; div_res_i = '0; div_fflags_i = '0;
    rsp_ready_i = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_start_valid", 64'(div_start_valid_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_finish_ready", 64'(div_finish_ready_o), 64'd0);
    check("rst_div_flush", 64'(div_flush_o), 64'd0);
    check("rst_div_opa", div_opa_o, 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag_o), 64'd0);
    check("rst_rsp_res", rsp_res_o, 64'd0);
    pending.delete();
    inflight = 1'b0; stub_busy = 1'b0; stub_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    new_req(4'd0);
    @(negedge clk);
    reset_dut();

    // Single f64 request, tag 5, immediate issue and zero-latency stub.
    dmin = 0; dmax = 0;
    cur_req = '{fmt: FMT_F64, opa: 64'h4000_0000_0000_0000, opb: 64'h3FF0_0000_0000_0000,
                rm: RM_RNE, tag: 4'd5};
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // Fill to DEPTH with the divider stalled; fifth push waits for the first issue.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Tags 1,2,3 back-to-back with random latency and random response backpressure.
    dmin = 0; dmax = 7;
    for (int t = 1; t <= 3; t++) begin
      new_req(4'(t));
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    // Finished result held off by rsp_ready_i=0 for 10 cycles; no new issue meanwhile.
    dmin = 0; dmax = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    // Flush with three queued, one in flight, and a request offered in the flush cycle.
    dmin = 30; dmax = 30;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    dmin = 0; dmax = 3;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

`ifdef FPDIV_ISSUE_QUEUE_BYPASS_EN
    // Bypass: empty and idle, tag 9 issues in the same cycle it is offered.
    dmin = 0; dmax = 0;
    new_req(4'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
`endif

    // Randomized traffic with occasional flushes.
    dmin = 0; dmax = 7;
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 39) == 0));
    end
    drain();

    // Reset in the middle of work clears everything like a flush.
    dmin = 20; dmax = 20;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    reset_dut();
    dmin = 0; dmax = 2;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
